adc_capture_ctrl: RTL

Responder to the active-low startCapture strobe from the capture-rate generator. Each falling edge of startCapture starts one conversion on an external serial ADC. The block pulses the convert line, waits the conversion time, shifts out DATA_WIDTH bits MSB-first over a CS/SCLK/SDO interface, then presents the sample with a one-cycle valid strobe. It sits between the rate generator and the capture buffer in the SmartFusion capture path.

---
 rtl/adc_capture_ctrl_pkg.sv | 22 ++
 rtl/adc_capture_ctrl_if.sv | 10 +
 rtl/adc_capture_ctrl_sclk_gen.sv | 44 ++++
 rtl/adc_capture_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/adc_capture_ctrl_pkg.sv
// Shared definitions for the serial ADC capture path: FSM encoding, clock
// frequency and default conversion parameters.
package adc_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DONE
  } cap_state_e;

  localparam int unsigned CLK_FREQ       = 20_000_000;
  localparam int unsigned DEF_DATA_WIDTH = 12;
  localparam int unsigned DEF_SCLK_DIV   = 4;
  localparam int unsigned DEF_CONV_TICKS = 40;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_capture_ctrl_if.sv
// Serial ADC pin bundle: convert strobe, chip select, serial clock and data.
interface adc_capture_if;
  logic adc_cnv;
  logic adc_cs_n;
  logic adc_sclk;
  logic adc_sdo;

  modport master (output adc_cnv, output adc_cs_n, output adc_sclk, input adc_sdo);
  modport slave  (input adc_cnv, input adc_cs_n, input adc_sclk, output adc_sdo);
endinterface

// File: rtl/adc_capture_ctrl_sclk_gen.sv
// SCLK generator: registered serial clock that idles low, with a half-period
// tick and a strobe on the clk edge where SCLK rises.
module adc_sclk_gen
  import adc_capture_ctrl_pkg::*;
#(
  parameter int unsigned SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic half_tick,
  output logic rise_strobe
);

  localparam int unsigned DIVW = cnt_width(SCLK_DIV);

  logic [DIVW-1:0] div_q, div_d;
  logic            sclk_q, sclk_d;

  always_comb begin
    half_tick   = en && (div_q == DIVW'(SCLK_DIV - 1));
    rise_strobe = half_tick && !sclk_q;
    div_d       = '0;
    sclk_d      = 1'b0;
    if (en) begin
      div_d  = half_tick ? '0 : div_q + 1'b1;
      sclk_d = half_tick ? ~sclk_q : sclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture controller: one serial ADC conversion per falling edge of the
// active-low startCapture strobe, result presented with a one-cycle valid.
module adc_capture_ctrl
  import adc_capture_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned SCLK_DIV   = DEF_SCLK_DIV,
  parameter int unsigned CONV_TICKS = DEF_CONV_TICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startCapture,
  input  logic                  overrun_clr,
  adc_capture_if.master         adc,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           sample_count
);

  localparam int unsigned CW = cnt_width(CONV_TICKS);
  localparam int unsigned BW = cnt_width(DATA_WIDTH);

  cap_state_e            state_q, state_d;
  logic                  start_prev_q, start_prev_d;
  logic [CW-1:0]         conv_cnt_q, conv_cnt_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  cnv_q, cnv_d;
  logic                  cs_n_q, cs_n_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           sample_count_q, sample_count_d;

  logic start_edge;
  logic shift_en;
  logic sclk;
  logic half_tick;
  logic rise_strobe;
  logic fall_strobe;

  assign shift_en = (state_q == SHIFT);

  adc_sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk         (clk),
    .rst_n       (reset),
    .en          (shift_en),
    .sclk        (sclk),
    .half_tick   (half_tick),
    .rise_strobe (rise_strobe)
  );

  always_comb begin
    start_edge     = !startCapture && start_prev_q;
    fall_strobe    = half_tick && sclk;
    state_d        = state_q;
    start_prev_d   = startCapture;
    conv_cnt_d     = conv_cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    sample_d       = sample_q;
    sample_count_d = sample_count_q;
    overrun_d      = overrun_clr ? 1'b0 : overrun_q;

    if (rise_strobe) begin
      shift_d = {shift_q[DATA_WIDTH-2:0], adc.adc_sdo};
    end

    unique case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = CONV;
          conv_cnt_d = '0;
        end
      end
      CONV: begin
        if (conv_cnt_q == CW'(CONV_TICKS - 1)) begin
          state_d   = SHIFT;
          bit_idx_d = BW'(DATA_WIDTH - 1);
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (fall_strobe) begin
          if (bit_idx_q == '0) begin
            state_d = DONE;
          end else begin
            bit_idx_d = bit_idx_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A set request wins over a same-cycle clear.
    if (start_edge && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    // Pin and status flops are loaded from the next state so they line up
    // with the state register rather than lagging it by a cycle.
    cnv_d   = (state_d == CONV);
    cs_n_d  = (state_d != SHIFT);
    valid_d = (state_d == DONE);
    if (state_d == DONE) begin
      sample_d       = shift_q;
      sample_count_d = sample_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      start_prev_q   <= 1'b1;
      conv_cnt_q     <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      sample_q       <= '0;
      valid_q        <= 1'b0;
      cnv_q          <= 1'b0;
      cs_n_q         <= 1'b1;
      overrun_q      <= 1'b0;
      sample_count_q <= '0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start_prev_d;
      conv_cnt_q     <= conv_cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      sample_q       <= sample_d;
      valid_q        <= valid_d;
      cnv_q          <= cnv_d;
      cs_n_q         <= cs_n_d;
      overrun_q      <= overrun_d;
      sample_count_q <= sample_count_d;
    end
  end

  assign adc.adc_cnv  = cnv_q;
  assign adc.adc_cs_n = cs_n_q;
  assign adc.adc_sclk = sclk;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign sample_count = sample_count_q;

endmodule
